// File: rtl/regfile_dump_reader.sv
// Debug/trace reader: sweeps the register file's asynchronous read port in index order
// and streams each captured word out over a valid/ready handshake.
module regfile_dump_reader #(
    parameter int NUM_REGS   = 32,
    parameter int FIRST_REG  = 0,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] C_FIRST = ADDR_WIDTH'(FIRST_REG);
    localparam logic [ADDR_WIDTH-1:0] C_LAST  = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_rf_addr;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic [ADDR_WIDTH-1:0]   r_out_index;
    logic                    r_busy;
    logic                    r_done;

    assign rf_addr   = r_rf_addr;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_out_index;
    assign busy      = r_busy;
    assign done      = r_done;

    // NOTE: every state register uses <= so all updates see the pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rf_addr   <= C_FIRST;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state   <= S_READ;
                        r_rf_addr <= C_FIRST;
                        r_busy    <= 1'b1;
                    end
                end
                S_READ: begin
                    if (abort) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_rf_addr   <= C_FIRST;
                        r_busy      <= 1'b0;
                    end else begin
                        // rf_data is combinational from the registered address, stable all cycle.
                        r_out_data  <= rf_data;
                        r_out_index <= r_rf_addr;
                        r_out_valid <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (abort) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_rf_addr   <= C_FIRST;
                        r_busy      <= 1'b0;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_out_index == C_LAST) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_rf_addr <= r_rf_addr + ADDR_WIDTH'(1);
                            r_state   <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_rf_addr <= C_FIRST;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader: a behavioural register file plus a
// per-sweep snapshot scoreboard predicts every streamed word and the done pulse.
module tb_regfile_dump_reader;

    localparam int NREG = 32;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic [5:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_index;
    logic        busy;
    logic        done;

    logic [31:0] rf [0:63];
    int          n_cmp;
    int          n_bad;
    int          n_done;

    regfile_dump_reader dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_index(out_index),
        .busy     (busy),
        .done     (done)
    );

    assign rf_data = rf[rf_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (done === 1'b1) n_done++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check({tag, "_valid"}, 64'(out_valid), 64'd0);
            check({tag, "_busy"}, 64'(busy), 64'd0);
            tick();
        end
    endtask

    // One sweep; negative indices disable the corresponding disturbance.
    task automatic sweep(input int ready_pct, input int stall_idx, input int abort_idx,
                         input int glitch_idx, input int reset_idx,
                         input int write_idx, input logic [31:0] write_val);
        logic [31:0] snap [0:NREG-1];
        int exp_idx, budget, stall_cnt, busy_cnt, done0;
        bit wrote, acc;
        for (int i = 0; i < NREG; i++) snap[i] = rf[i];
        done0 = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_addr", 64'(rf_addr), 64'd0);
        exp_idx = 0; budget = 3000; stall_cnt = 0; busy_cnt = 0; wrote = 0;
        while (exp_idx < NREG && budget > 0) begin
            budget--;
            if (busy) busy_cnt++;
            out_ready = ($urandom_range(0, 99) < ready_pct);
            if (out_valid) begin
                check("word_idx", 64'(out_index), 64'(exp_idx));
                check("word_data", 64'(out_data), 64'(snap[exp_idx]));
                check("word_addr", 64'(rf_addr), 64'(exp_idx));
                if (exp_idx == stall_idx && stall_cnt < 5) begin
                    out_ready = 1'b0;
                    stall_cnt++;
                end
                if (exp_idx == write_idx && !wrote) begin
                    rf[write_idx] = write_val;
                    wrote = 1;
                end
                if (exp_idx == abort_idx) begin
                    abort = 1'b1;
                    out_ready = 1'b1;
                    tick();
                    abort = 1'b0;
                    check("abort_valid", 64'(out_valid), 64'd0);
                    check("abort_busy", 64'(busy), 64'd0);
                    check("abort_addr", 64'(rf_addr), 64'd0);
                    check("abort_done", 64'(done), 64'd0);
                    check_idle("abort_idle", 4);
                    check("abort_no_done", 64'(n_done - done0), 64'd0);
                    return;
                end
            end else if (busy && exp_idx == reset_idx) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check("rst_addr", 64'(rf_addr), 64'd0);
                check("rst_valid", 64'(out_valid), 64'd0);
                check("rst_data", 64'(out_data), 64'd0);
                check("rst_index", 64'(out_index), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_done", 64'(done), 64'd0);
                check_idle("rst_idle", 5);
                check("rst_no_done", 64'(n_done - done0), 64'd0);
                return;
            end
            start = (exp_idx == glitch_idx);
            acc = out_valid && out_ready;
            tick();
            start = 1'b0;
            if (acc) exp_idx++;
        end
        out_ready = 1'b0;
        check("sweep_timeout", 64'(exp_idx), 64'(NREG));
        if (stall_idx >= 0) check("stall_len", 64'(stall_cnt), 64'd5);
        if (ready_pct >= 100 && stall_idx < 0) check("busy_cycles", 64'(busy_cnt), 64'd64);
        check("done_pulse", 64'(done), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("done_valid", 64'(out_valid), 64'd0);
        start = (glitch_idx >= 0);
        tick();
        start = 1'b0;
        check("after_done", 64'(done), 64'd0);
        check("after_addr", 64'(rf_addr), 64'd0);
        check_idle("post_sweep", 3);
        check("done_count", 64'(n_done - done0), 64'd1);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; n_done = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 64; i++) rf[i] = 32'hA5A5_0000 + 32'(i);
        tick(); tick();
        check("reset_addr", 64'(rf_addr), 64'd0);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_data", 64'(out_data), 64'd0);
        check("reset_index", 64'(out_index), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();

        // start together with abort must not launch a sweep
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check_idle("start_abort", 3);

        sweep(100, -1, -1, -1, -1, -1, 32'h0);         // full sweep, ready tied high
        sweep(100,  3, -1, -1, -1, -1, 32'h0);         // backpressure on word 3
        sweep(100, -1, 10, -1, -1, -1, 32'h0);         // abort in SEND at index 10
        sweep(100, -1, -1, -1, -1, -1, 32'h0);         // restart from index 0
        sweep(100, -1, -1,  7, -1, -1, 32'h0);         // start mid-sweep and during DONE
        sweep(100, -1, -1, -1, 15, -1, 32'h0);         // reset in READ at index 15
        sweep(100, -1, -1, -1, -1,  5, 32'h1234_5678); // late write keeps old word
        sweep(100, -1, -1, -1, -1, -1, 32'h0);         // new value visible next sweep

        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < NREG; i++) rf[i] = $urandom;
            sweep(30 + 20 * s, -1, -1, -1, -1, -1, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
